// File: rtl/decode_pipe.sv
// Decode stage: register file, per-register pending-write scoreboard and a one-entry registered output slot.
// Optional same-cycle writeback forwarding is compiled in when DECODE_BYPASS_EN is defined.
module decode_pipe #(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  input  logic [WIDTH-1:0] pc_2,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             reg_we,
  input  logic             sign_ext,
  input  logic             imm5,
  input  logic             is_jal,
  input  logic [1:0]       dst_mode,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rd1,
  output logic [WIDTH-1:0] out_rd2,
  output logic [WIDTH-1:0] out_immd,
  output logic [WIDTH-1:0] out_pc_2,
  output logic [AW-1:0]    out_dst,
  output logic             out_we,
  output logic             out_jal
);

  typedef struct packed {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] immd;
    logic [WIDTH-1:0] pc_2;
    logic [AW-1:0]    dst;
    logic             we;
    logic             jal;
  } out_t;

  logic [WIDTH-1:0] rf_q [NREG];
  logic [NREG-1:0]  pend_q, pend_d, pend_vis;
  logic [NREG-1:0]  wb_mask, set_mask;
  logic [AW-1:0]    rs, rt, rd, dst;
  logic [WIDTH-1:0] rd1, rd2, immd;
  logic             hazard, slot_free, accept;
  out_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             unused_instr_bits;

  assign rs = instr[8 +: AW];
  assign rt = instr[5 +: AW];
  assign rd = instr[2 +: AW];
  assign unused_instr_bits = ^instr[15:11];

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_mask = '0;
    if (wb_en) wb_mask[wb_sel] = 1'b1;
  end

  always_comb begin
    case (dst_mode)
      2'd0:    dst = rd;
      2'd1:    dst = rt;
      2'd2:    dst = rs;
      default: dst = AW'(NREG - 1);
    endcase
  end

`ifdef DECODE_BYPASS_EN
  // A writeback landing this cycle both supplies the operand and retires the pending write.
  assign pend_vis = pend_q & ~wb_mask;
  assign rd1      = (wb_en && wb_sel == rs) ? wb_data : rf_q[rs];
  assign rd2      = (wb_en && wb_sel == rt) ? wb_data : rf_q[rt];
`else
  assign pend_vis = pend_q;
  assign rd1      = rf_q[rs];
  assign rd2      = rf_q[rt];
`endif

  assign hazard    = (use_rs & pend_vis[rs]) | (use_rt & pend_vis[rt]);
  assign slot_free = ~out_valid_q | out_ready;
  assign in_ready  = slot_free & ~hazard & ~flush & ~rst;
  assign accept    = in_valid & in_ready;

  always_comb begin
    if (imm5) immd = {{(WIDTH-5){sign_ext & instr[4]}}, instr[4:0]};
    else      immd = {{(WIDTH-8){sign_ext & instr[7]}}, instr[7:0]};
  end

  // The set mask is applied after the clear, so a new writer wins over a retiring one.
  always_comb begin
    set_mask = '0;
    if (accept && reg_we) set_mask[dst] = 1'b1;
    pend_d = flush ? '0 : ((pend_q & ~wb_mask) | set_mask);
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d.rd1   = rd1;
      out_d.rd2   = rd2;
      out_d.immd  = immd;
      out_d.pc_2  = pc_2;
      out_d.dst   = dst;
      out_d.we    = reg_we;
      out_d.jal   = is_jal;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      // NOTE: the register file is reset too, because software may read any register before writing it.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      if (wb_en) rf_q[wb_sel] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd1   = out_q.rd1;
  assign out_rd2   = out_q.rd2;
  assign out_immd  = out_q.immd;
  assign out_pc_2  = out_q.pc_2;
  assign out_dst   = out_q.dst;
  assign out_we    = out_q.we;
  assign out_jal   = out_q.jal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: expected output records are queued on accept and compared when the slot hands off.
// Expectations follow DECODE_BYPASS_EN when it is defined for the build.
module tb_decode_pipe;

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] instr, pc_2;
  logic        use_rs, use_rt, reg_we, sign_ext, imm5, is_jal;
  logic [1:0]  dst_mode;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [15:0] out_rd1, out_rd2, out_immd, out_pc_2;
  logic [2:0]  out_dst;
  logic        out_we, out_jal;

  typedef struct {
    logic [15:0] rd1, rd2, immd, pc2;
    logic [2:0]  dst;
    logic        we, jal;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rf_m [8];
  logic [15:0] pc_v;
  int          n_tests = 0;
  int          n_fail  = 0;

  decode_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_2(pc_2),
    .use_rs(use_rs), .use_rt(use_rt), .reg_we(reg_we),
    .sign_ext(sign_ext), .imm5(imm5), .is_jal(is_jal), .dst_mode(dst_mode),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_immd(out_immd), .out_pc_2(out_pc_2),
    .out_dst(out_dst), .out_we(out_we), .out_jal(out_jal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] imm_exp(input logic [15:0] ins, input logic i5, input logic sx);
    int v;
    if (i5) begin
      v = int'(ins & 16'h001F);
      if (sx && v >= 16) v -= 32;
    end else begin
      v = int'(ins & 16'h00FF);
      if (sx && v >= 128) v -= 256;
    end
    return v[15:0];
  endfunction

  function automatic logic [15:0] rd_exp(input logic [2:0] idx);
    if (BYP && wb_en && wb_sel == idx) return wb_data;
    return rf_m[idx];
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.rd1  = rd_exp(instr[10:8]);
    e.rd2  = rd_exp(instr[7:5]);
    e.immd = imm_exp(instr, imm5, sign_ext);
    e.pc2  = pc_2;
    case (dst_mode)
      2'd0:    e.dst = instr[4:2];
      2'd1:    e.dst = instr[7:5];
      2'd2:    e.dst = instr[10:8];
      default: e.dst = 3'd7;
    endcase
    e.we  = reg_we;
    e.jal = is_jal;
    return e;
  endfunction

  task automatic set_instr(input logic [15:0] ins, input logic urs, input logic urt, input logic we,
                           input logic sx, input logic i5, input logic jal, input logic [1:0] dm);
    instr = ins; use_rs = urs; use_rt = urt; reg_we = we;
    sign_ext = sx; imm5 = i5; is_jal = jal; dst_mode = dm;
    pc_v += 16'd2;
    pc_2 = pc_v;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] sel, input logic [15:0] data);
    wb_en = en; wb_sel = sel; wb_data = data;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst && wb_en) rf_m[wb_sel] = wb_data;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    advance();
  endtask

  // Checks in_ready mid-cycle and, when the bench expects an accept, records the output it predicts.
  task automatic offer(input logic exp_rdy, input string tag);
    @(negedge clk);
    check(tag, in_ready, exp_rdy);
    if (exp_rdy && in_valid) sb.push_back(mk_exp());
    advance();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("out_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_rd1",  out_rd1,  e.rd1);
        check("out_rd2",  out_rd2,  e.rd2);
        check("out_immd", out_immd, e.immd);
        check("out_pc_2", out_pc_2, e.pc2);
        check("out_dst",  out_dst,  e.dst);
        check("out_we",   out_we,   e.we);
        check("out_jal",  out_jal,  e.jal);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
    pc_v = 16'h0100;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1;
    set_instr(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    set_wb(1'b1, 3'd7, 16'h7777);

    // Reset overrides accept and writeback.
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    advance();
    @(negedge clk);
    check("rst_in_ready2", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_rd1, out_rd2, out_immd, out_pc_2}, 64'h0);
    check("rst_out_ctl", {out_dst, out_we, out_jal}, 0);
    advance();

    rst = 1'b0; in_valid = 1'b0;
    set_wb(1'b0, 3'd0, 16'h0000);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    advance();

    set_wb(1'b1, 3'd1, 16'h1111); offer(1, "wb_r1_ready");
    set_wb(1'b1, 3'd2, 16'h2222); step();
    set_wb(1'b1, 3'd4, 16'h4444); step();
    set_wb(1'b0, 3'd0, 16'h0000);

    // Immediate forms, back to back.
    in_valid = 1'b1;
    set_instr(16'h001F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0); offer(1, "imm5_sext_acc");
    set_instr(16'h001F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); offer(1, "imm5_zext_acc");
    set_instr(16'h0080, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); offer(1, "imm8_sext_acc");
    set_instr(16'h0153, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3); offer(1, "jal_dst3_acc");
    set_instr(16'h07FF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); offer(1, "r7_after_rst_acc");
    in_valid = 1'b0; step();

    // RAW hazard on r3.
    in_valid = 1'b1;
    set_instr(16'h000C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0); offer(1, "raw_writer_acc");
    set_instr(16'h0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    offer(0, "raw_stall0");
    offer(0, "raw_stall1");
    set_wb(1'b1, 3'd3, 16'hBEEF);
    if (BYP) begin
      offer(1, "raw_bypass_acc");
    end else begin
      offer(0, "raw_wb_stall");
      set_wb(1'b0, 3'd0, 16'h0000);
      offer(1, "raw_after_wb_acc");
    end
    set_wb(1'b0, 3'd0, 16'h0000);
    in_valid = 1'b0; step();

    // Backpressure holds the slot and blocks intake until released.
    out_ready = 1'b0; in_valid = 1'b1;
    set_instr(16'h0120, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); offer(1, "bp_a_acc");
    set_instr(16'h0240, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < 3; i++) begin
      offer(0, "bp_stall");
      check("bp_valid", out_valid, 1);
      check("bp_hold_rd", {out_rd1, out_rd2}, {sb[0].rd1, sb[0].rd2});
      check("bp_hold_misc", {out_immd, out_pc_2}, {sb[0].immd, sb[0].pc2});
    end
    out_ready = 1'b1;
    offer(1, "bp_release_acc");
    in_valid = 1'b0; step();

    // Writer to r5 accepted while r5 retires: the new pending bit survives.
    in_valid = 1'b1;
    set_wb(1'b1, 3'd5, 16'h5555);
    set_instr(16'h0014, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0); offer(1, "sc_writer_acc");
    set_wb(1'b0, 3'd0, 16'h0000);
    set_instr(16'h0500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    offer(0, "sc_stall0");
    offer(0, "sc_stall1");
    set_wb(1'b1, 3'd5, 16'h5A5A);
    if (BYP) begin
      offer(1, "sc_bypass_acc");
    end else begin
      offer(0, "sc_wb_stall");
      set_wb(1'b0, 3'd0, 16'h0000);
      offer(1, "sc_after_wb_acc");
    end
    set_wb(1'b0, 3'd0, 16'h0000);
    in_valid = 1'b0; step();

    // Flush with r2 and r4 pending and the slot occupied.
    in_valid = 1'b1;
    set_instr(16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1); offer(1, "fl_writer_r2_acc");
    set_instr(16'h0400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2); offer(1, "fl_writer_r4_acc");
    out_ready = 1'b0; flush = 1'b1;
    set_wb(1'b1, 3'd6, 16'h6666);
    set_instr(16'h0280, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    offer(0, "fl_blocked");
    check("fl_sb_one", sb.size(), 1);
    if (sb.size() != 0) void'(sb.pop_front());
    flush = 1'b0; out_ready = 1'b1;
    set_wb(1'b0, 3'd0, 16'h0000);
    check("fl_out_valid", out_valid, 0);
    offer(1, "fl_reader_r2_acc");
    set_instr(16'h06A0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); offer(1, "fl_wb_r6_acc");
    in_valid = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("sb_drained", sb.size(), 0);
    step();
    check("end_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
